// File: rtl/hm_scan_ctrl.sv
`timescale 1ns/1ps
// Host-memory page scan sequencer: issues one fetch per 4 KiB page with bounded retries,
// then hands each fetched page to a consumer over valid/ready before the next fetch.
module hm_scan_ctrl #(
    parameter int unsigned PFN_W  = 52,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned RTY_W  = 4,
    parameter int unsigned WDOG_W = 20
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [PFN_W-1:0] cfg_base,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic [RTY_W-1:0] cfg_retries,
    input  logic [CNT_W-1:0] cfg_gap,
    input  logic             ctl_start,
    input  logic             ctl_abort,
    output logic             hm_start,
    output logic [63:0]      hm_addr,
    input  logic             hm_end,
    input  logic             hm_tx_timeout,
    input  logic             hm_rx_timeout,
    output logic             page_valid,
    input  logic             page_ready,
    output logic [CNT_W-1:0] page_idx,
    output logic             busy,
    output logic             scan_done,
    output logic             scan_error,
    output logic [15:0]      stat_retries,
    output logic [15:0]      stat_fails
);
    localparam int unsigned ADDR_W = 64;
    localparam int unsigned STAT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_DELIVER = 3'd3,
        S_GAP     = 3'd4
    } state_t;

    state_t              r_state, w_state;
    logic [PFN_W-1:0]    r_base, w_base;
    logic [CNT_W-1:0]    r_count, w_count;
    logic [RTY_W-1:0]    r_retries, w_retries;
    logic [CNT_W-1:0]    r_gap, w_gap;
    logic [CNT_W-1:0]    r_idx, w_idx;
    logic [RTY_W-1:0]    r_tries, w_tries;
    logic [WDOG_W-1:0]   r_wdog, w_wdog;
    logic [CNT_W-1:0]    r_gap_cnt, w_gap_cnt;
    logic [ADDR_W-1:0]   r_addr, w_addr;
    logic                r_hm_start, w_hm_start;
    logic                r_page_valid, w_page_valid;
    logic                r_busy, w_busy;
    logic                r_scan_done, w_scan_done;
    logic                r_scan_error, w_scan_error;
    logic [STAT_W-1:0]   r_stat_retries, w_stat_retries;
    logic [STAT_W-1:0]   r_stat_fails, w_stat_fails;
    logic                w_fail;
    logic                w_advance;
    logic [CNT_W-1:0]    w_gap_load;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
    endfunction

    // State register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) r_state <= S_IDLE;
        else         r_state <= w_state;
    end

    // Next-state and next-output logic
    always_comb begin
        w_state        = r_state;
        w_base         = r_base;
        w_count        = r_count;
        w_retries      = r_retries;
        w_gap          = r_gap;
        w_idx          = r_idx;
        w_tries        = r_tries;
        w_wdog         = r_wdog;
        w_gap_cnt      = r_gap_cnt;
        w_addr         = r_addr;
        w_hm_start     = 1'b0;
        w_page_valid   = r_page_valid;
        w_busy         = r_busy;
        w_scan_done    = 1'b0;
        w_scan_error   = 1'b0;
        w_stat_retries = r_stat_retries;
        w_stat_fails   = r_stat_fails;
        w_advance      = 1'b0;
        w_fail         = hm_tx_timeout | hm_rx_timeout | (r_wdog == {WDOG_W{1'b1}});
        // A gap of 0 still spends one cycle in GAP
        w_gap_load     = (r_gap == '0) ? '0 : r_gap - CNT_W'(1);

        case (r_state)
            S_IDLE: begin
                if (ctl_start) begin
                    w_base         = cfg_base;
                    w_count        = cfg_count;
                    w_retries      = cfg_retries;
                    w_gap          = cfg_gap;
                    w_idx          = '0;
                    w_tries        = '0;
                    w_stat_retries = '0;
                    w_stat_fails   = '0;
                    if (cfg_count == '0) begin
                        w_scan_done = 1'b1;
                    end else begin
                        w_state    = S_ISSUE;
                        w_busy     = 1'b1;
                        w_hm_start = 1'b1;
                        w_addr     = ADDR_W'({cfg_base, 12'h000});
                    end
                end
            end
            S_ISSUE: begin
                w_state = S_WAIT;
                w_wdog  = '0;
            end
            S_WAIT: begin
                if (hm_end) begin
                    w_state      = S_DELIVER;
                    w_page_valid = 1'b1;
                end else if (w_fail) begin
                    if (r_tries < r_retries) begin
                        w_tries        = r_tries + RTY_W'(1);
                        w_stat_retries = sat_inc(r_stat_retries);
                        w_state        = S_GAP;
                        w_gap_cnt      = w_gap_load;
                    end else begin
                        w_stat_fails = sat_inc(r_stat_fails);
                        w_advance    = 1'b1;
                    end
                end else begin
                    w_wdog = r_wdog + WDOG_W'(1);
                end
            end
            S_DELIVER: begin
                if (page_ready) begin
                    w_page_valid = 1'b0;
                    w_advance    = 1'b1;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state    = S_ISSUE;
                    w_hm_start = 1'b1;
                    w_addr     = ADDR_W'({r_base + PFN_W'(r_idx), 12'h000});
                end else begin
                    w_gap_cnt = r_gap_cnt - CNT_W'(1);
                end
            end
            default: w_state = S_IDLE;
        endcase

        // Page finished (delivered or skipped): next page or end of scan
        if (w_advance) begin
            w_tries = '0;
            if (r_idx == r_count - CNT_W'(1)) begin
                w_state      = S_IDLE;
                w_busy       = 1'b0;
                w_scan_done  = 1'b1;
                w_scan_error = (w_stat_fails != '0);
            end else begin
                w_idx     = r_idx + CNT_W'(1);
                w_state   = S_GAP;
                w_gap_cnt = w_gap_load;
            end
        end

        // Abort overrides any same-cycle progress
        if (ctl_abort && (r_state != S_IDLE)) begin
            w_state        = S_IDLE;
            w_busy         = 1'b0;
            w_page_valid   = 1'b0;
            w_hm_start     = 1'b0;
            w_scan_done    = 1'b1;
            w_scan_error   = 1'b1;
            w_idx          = r_idx;
            w_tries        = r_tries;
            w_stat_retries = r_stat_retries;
            w_stat_fails   = r_stat_fails;
        end
    end

    // Datapath and output registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_base         <= '0;
            r_count        <= '0;
            r_retries      <= '0;
            r_gap          <= '0;
            r_idx          <= '0;
            r_tries        <= '0;
            r_wdog         <= '0;
            r_gap_cnt      <= '0;
            r_addr         <= '0;
            r_hm_start     <= 1'b0;
            r_page_valid   <= 1'b0;
            r_busy         <= 1'b0;
            r_scan_done    <= 1'b0;
            r_scan_error   <= 1'b0;
            r_stat_retries <= '0;
            r_stat_fails   <= '0;
        end else begin
            r_base         <= w_base;
            r_count        <= w_count;
            r_retries      <= w_retries;
            r_gap          <= w_gap;
            r_idx          <= w_idx;
            r_tries        <= w_tries;
            r_wdog         <= w_wdog;
            r_gap_cnt      <= w_gap_cnt;
            r_addr         <= w_addr;
            r_hm_start     <= w_hm_start;
            r_page_valid   <= w_page_valid;
            r_busy         <= w_busy;
            r_scan_done    <= w_scan_done;
            r_scan_error   <= w_scan_error;
            r_stat_retries <= w_stat_retries;
            r_stat_fails   <= w_stat_fails;
        end
    end

    assign hm_start     = r_hm_start;
    assign hm_addr      = r_addr;
    assign page_valid   = r_page_valid;
    assign page_idx     = r_idx;
    assign busy         = r_busy;
    assign scan_done    = r_scan_done;
    assign scan_error   = r_scan_error;
    assign stat_retries = r_stat_retries;
    assign stat_fails   = r_stat_fails;

endmodule

// File: tb/tb_hm_scan_ctrl.sv
`timescale 1ns/1ps
// Bench for hm_scan_ctrl: scenario table, hand-written corner sequences and randomized
// scans, all checked against a page-level model of fetch/retry/deliver outcomes.
module tb_hm_scan_ctrl;
    localparam int unsigned PFN_W  = 52;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned RTY_W  = 4;
    localparam int unsigned WDOG_W = 8;
    localparam int MAXF = 64;
    localparam int OC_END = 0, OC_TX = 1, OC_RX = 2, OC_BOTH = 3, OC_NONE = 4;

    logic             sys_clk = 1'b0;
    logic             sys_rst = 1'b1;
    logic [PFN_W-1:0] cfg_base = '0;
    logic [CNT_W-1:0] cfg_count = '0;
    logic [RTY_W-1:0] cfg_retries = '0;
    logic [CNT_W-1:0] cfg_gap = '0;
    logic             ctl_start = 1'b0;
    logic             ctl_abort = 1'b0;
    logic             hm_start;
    logic [63:0]      hm_addr;
    logic             hm_end = 1'b0;
    logic             hm_tx_timeout = 1'b0;
    logic             hm_rx_timeout = 1'b0;
    logic             page_valid;
    logic             page_ready = 1'b0;
    logic [CNT_W-1:0] page_idx;
    logic             busy;
    logic             scan_done;
    logic             scan_error;
    logic [15:0]      stat_retries;
    logic [15:0]      stat_fails;

    hm_scan_ctrl #(.PFN_W(PFN_W), .CNT_W(CNT_W), .RTY_W(RTY_W), .WDOG_W(WDOG_W)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .cfg_base(cfg_base), .cfg_count(cfg_count), .cfg_retries(cfg_retries), .cfg_gap(cfg_gap),
        .ctl_start(ctl_start), .ctl_abort(ctl_abort),
        .hm_start(hm_start), .hm_addr(hm_addr), .hm_end(hm_end),
        .hm_tx_timeout(hm_tx_timeout), .hm_rx_timeout(hm_rx_timeout),
        .page_valid(page_valid), .page_ready(page_ready), .page_idx(page_idx),
        .busy(busy), .scan_done(scan_done), .scan_error(scan_error),
        .stat_retries(stat_retries), .stat_fails(stat_fails)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Fetch outcome plan, one entry per issued fetch in order
    int plan [MAXF];

    task automatic plan_all_end();
        for (int i = 0; i < MAXF; i++) plan[i] = OC_END;
    endtask

    // Reference model: page-by-page outcome of a scan
    logic [63:0] m_addr [$];
    int          m_deliv [$];
    int          m_rty, m_fail;

    function automatic void model(input logic [PFN_W-1:0] base, input int count, input int retries);
        int f, tries, oc;
        bit fin;
        logic [PFN_W-1:0] pfn;
        f = 0; m_rty = 0; m_fail = 0;
        m_addr.delete(); m_deliv.delete();
        for (int idx = 0; idx < count; idx++) begin
            tries = 0; fin = 1'b0;
            while (!fin) begin
                pfn = base + PFN_W'(idx);
                m_addr.push_back({pfn, 12'h000});
                oc = (f < MAXF) ? plan[f] : OC_END;
                f++;
                if (oc == OC_END || oc == OC_BOTH) begin
                    m_deliv.push_back(idx); fin = 1'b1;
                end else if (tries < retries) begin
                    tries++;
                    if (m_rty < 65535) m_rty++;
                end else begin
                    if (m_fail < 65535) m_fail++;
                    fin = 1'b1;
                end
            end
        end
    endfunction

    // Drives one scan as fetcher and consumer, then compares against expectations and the model
    task automatic run_scan(input string tag, input logic [PFN_W-1:0] base, input int count,
                            input int retries, input int gap, input int lat, input int rdy_lo,
                            input int exp_nf, input int exp_nd, input int exp_rty, input int exp_fail,
                            input bit exp_err, input logic [63:0] exp_last);
        logic [63:0] got_addr [$];
        int got_deliv [$];
        int cyc, fcnt, ev_cnt, ev_oc, rdy_cnt, hs_cyc, gap_bad, ovl_bad, addr_bad, dlv_bad;
        bit done, prev_v, err_seen, busy_bad;
        logic [15:0] s_rty, s_fail;
        model(base, count, retries);
        cyc = 0; fcnt = 0; ev_cnt = 0; ev_oc = OC_END; rdy_cnt = 0; hs_cyc = -1;
        gap_bad = 0; ovl_bad = 0; addr_bad = 0; dlv_bad = 0;
        done = 1'b0; prev_v = 1'b0; err_seen = 1'b0; busy_bad = 1'b0; s_rty = '0; s_fail = '0;
        @(negedge sys_clk);
        cfg_base = base; cfg_count = CNT_W'(count); cfg_retries = RTY_W'(retries);
        cfg_gap = CNT_W'(gap); ctl_start = 1'b1;
        while (!done && cyc < 3000) begin
            @(negedge sys_clk);
            cyc++;
            ctl_start = (cyc == 2);
            if (cyc == 1) begin
                cfg_base = ~base; cfg_count = 16'hFFFF; cfg_retries = 4'hF; cfg_gap = 16'd7;
            end
            hm_end = 1'b0; hm_tx_timeout = 1'b0; hm_rx_timeout = 1'b0; page_ready = 1'b0;
            if (hm_start) begin
                got_addr.push_back(hm_addr);
                if (page_valid) ovl_bad++;
                if (hs_cyc >= 0) begin
                    if (cyc - hs_cyc != ((gap < 1) ? 1 : gap) + 1) gap_bad++;
                    hs_cyc = -1;
                end
                ev_oc = (fcnt < MAXF) ? plan[fcnt] : OC_END;
                fcnt++;
                ev_cnt = (ev_oc == OC_NONE) ? 0 : lat;
            end else if (ev_cnt > 0) begin
                ev_cnt--;
                if (ev_cnt == 0) begin
                    case (ev_oc)
                        OC_END:  hm_end = 1'b1;
                        OC_TX:   hm_tx_timeout = 1'b1;
                        OC_RX:   hm_rx_timeout = 1'b1;
                        OC_BOTH: begin hm_end = 1'b1; hm_rx_timeout = 1'b1; end
                        default: ;
                    endcase
                end
            end
            if (page_valid) begin
                if (!prev_v) rdy_cnt = rdy_lo;
                if (rdy_cnt > 0) rdy_cnt--;
                else begin
                    page_ready = 1'b1;
                    got_deliv.push_back(int'(page_idx));
                    hs_cyc = cyc;
                end
            end
            prev_v = page_valid;
            if (scan_done) begin
                done = 1'b1; err_seen = scan_error; busy_bad = busy;
                s_rty = stat_retries; s_fail = stat_fails;
            end
        end
        ctl_start = 1'b0; page_ready = 1'b0;
        hm_end = 1'b0; hm_tx_timeout = 1'b0; hm_rx_timeout = 1'b0;
        for (int i = 0; i < got_addr.size() && i < m_addr.size(); i++)
            if (got_addr[i] !== m_addr[i]) addr_bad++;
        for (int i = 0; i < got_deliv.size() && i < m_deliv.size(); i++)
            if (got_deliv[i] != m_deliv[i]) dlv_bad++;
        check({tag, " scan_done seen"}, done, 1);
        check({tag, " fetch count"}, got_addr.size(), exp_nf);
        check({tag, " model fetch count"}, got_addr.size(), m_addr.size());
        check({tag, " fetch addr errors"}, addr_bad, 0);
        check({tag, " deliver count"}, got_deliv.size(), exp_nd);
        check({tag, " deliver idx errors"}, dlv_bad + (got_deliv.size() != m_deliv.size()), 0);
        check({tag, " stat_retries"}, s_rty, exp_rty);
        check({tag, " stat_fails"}, s_fail, exp_fail);
        check({tag, " scan_error"}, err_seen, exp_err);
        check({tag, " busy at done"}, busy_bad, 0);
        check({tag, " gap timing errors"}, gap_bad, 0);
        check({tag, " fetch during valid"}, ovl_bad, 0);
        if (got_addr.size() > 0) check({tag, " last addr"}, got_addr[got_addr.size()-1], exp_last);
    endtask

    task automatic wait_start(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (hm_start) ok = 1'b1;
            else @(negedge sys_clk);
        end
        check({tag, " hm_start seen"}, ok, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " hm_start"}, hm_start, 0);
        check({tag, " hm_addr"}, hm_addr, 0);
        check({tag, " page_valid"}, page_valid, 0);
        check({tag, " page_idx"}, page_idx, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " scan_done"}, scan_done, 0);
        check({tag, " scan_error"}, scan_error, 0);
        check({tag, " stat_retries"}, stat_retries, 0);
        check({tag, " stat_fails"}, stat_fails, 0);
    endtask

    typedef struct {
        logic [PFN_W-1:0] base;
        int count, retries, gap, lat, rdy_lo;
        logic [31:0] plan;     // 4-bit outcome per fetch, fetch 0 in the low nibble
        int nf, nd, rty, fail;
        bit err;
        logic [63:0] last;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #500000;
        $display("FAIL global timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] r64;
        logic [PFN_W-1:0] rb;
        int rc, rr, rg, rl, rd, q, cnt;

        tbl[0] = '{52'h12345, 3, 0, 0, 10, 0, 32'h0,  3, 3, 0, 0, 1'b0, 64'h12347000};
        tbl[1] = '{52'h00400, 2, 2, 1, 5, 1,  32'h12, 4, 2, 2, 0, 1'b0, 64'h00401000};
        tbl[2] = '{52'h00800, 2, 1, 0, 4, 0,  32'h21, 3, 1, 1, 1, 1'b1, 64'h00801000};
        tbl[3] = '{52'hF_FFFF_FFFF_FFFF, 2, 0, 0, 3, 0, 32'h0, 2, 2, 0, 0, 1'b0, 64'h0};
        tbl[4] = '{52'h0ABCD, 2, 0, 3, 6, 50, 32'h0,  2, 2, 0, 0, 1'b0, 64'h0ABCE000};
        tbl[5] = '{52'h00100, 1, 0, 2, 7, 0,  32'h3,  1, 1, 0, 0, 1'b0, 64'h00100000};
        tbl[6] = '{52'h00200, 1, 1, 0, 2, 0,  32'h4,  2, 1, 1, 0, 1'b0, 64'h00200000};
        tbl[7] = '{52'h00300, 1, 0, 0, 2, 0,  32'h4,  1, 0, 0, 1, 1'b1, 64'h00300000};

        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check_all_zero("reset");

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < MAXF; i++)
                plan[i] = (i < 8) ? int'(tbl[t].plan[i*4 +: 4]) : OC_END;
            run_scan($sformatf("vec%0d", t), tbl[t].base, tbl[t].count, tbl[t].retries, tbl[t].gap,
                     tbl[t].lat, tbl[t].rdy_lo, tbl[t].nf, tbl[t].nd, tbl[t].rty, tbl[t].fail,
                     tbl[t].err, tbl[t].last);
        end

        // Zero-length scan completes immediately without fetching
        @(negedge sys_clk);
        cfg_count = '0; ctl_start = 1'b1;
        @(negedge sys_clk);
        ctl_start = 1'b0;
        check("count0 scan_done", scan_done, 1);
        check("count0 scan_error", scan_error, 0);
        check("count0 busy", busy, 0);
        check("count0 hm_start", hm_start, 0);
        @(negedge sys_clk);
        check("count0 done pulse width", scan_done, 0);
        check("count0 no fetch", hm_start, 0);

        // Abort during WAIT, then a late hm_end that must be dropped
        plan_all_end();
        cfg_base = 52'h55555; cfg_count = 16'd3; cfg_retries = '0; cfg_gap = '0; ctl_start = 1'b1;
        @(negedge sys_clk);
        ctl_start = 1'b0;
        wait_start("abort");
        repeat (3) @(negedge sys_clk);
        ctl_abort = 1'b1;
        @(negedge sys_clk);
        ctl_abort = 1'b0;
        check("abort scan_done", scan_done, 1);
        check("abort scan_error", scan_error, 1);
        check("abort busy", busy, 0);
        check("abort page_valid", page_valid, 0);
        check("abort hm_start", hm_start, 0);
        hm_end = 1'b1;
        @(negedge sys_clk);
        hm_end = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (busy || page_valid || scan_done || hm_start) cnt++;
            @(negedge sys_clk);
        end
        check("abort late event activity", cnt, 0);
        run_scan("restart", 52'h55555, 1, 0, 0, 3, 0, 1, 1, 0, 0, 1'b0, 64'h55555000);

        // Reset in the middle of a retried fetch
        @(negedge sys_clk);
        cfg_base = 52'h00777; cfg_count = 16'd2; cfg_retries = 4'd2; cfg_gap = '0; ctl_start = 1'b1;
        @(negedge sys_clk);
        ctl_start = 1'b0;
        wait_start("rst");
        @(negedge sys_clk);
        hm_rx_timeout = 1'b1;
        @(negedge sys_clk);
        hm_rx_timeout = 1'b0;
        check("rst pre stat_retries", stat_retries, 1);
        wait_start("rst reissue");
        check("rst reissue addr", hm_addr, 64'h00777000);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        check_all_zero("midrst");

        // Randomized scans against the model
        for (int n = 0; n < 12; n++) begin
            r64 = {$urandom(), $urandom()};
            rb = r64[PFN_W-1:0];
            if ($urandom_range(0, 3) == 0) rb = {PFN_W{1'b1}} - PFN_W'($urandom_range(0, 2));
            rc = $urandom_range(1, 5);
            rr = $urandom_range(0, 3);
            rg = $urandom_range(0, 4);
            rl = $urandom_range(1, 6);
            rd = $urandom_range(0, 3);
            for (int i = 0; i < MAXF; i++) begin
                q = $urandom_range(0, 9);
                plan[i] = (q < 6) ? OC_END : (q == 6) ? OC_TX : (q == 7) ? OC_RX :
                          (q == 8) ? OC_BOTH : OC_TX;
            end
            model(rb, rc, rr);
            run_scan($sformatf("rand%0d", n), rb, rc, rr, rg, rl, rd, m_addr.size(),
                     m_deliv.size(), m_rty, m_fail, (m_fail != 0), m_addr[m_addr.size()-1]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hm_scan_ctrl.md
Name: hm_scan_ctrl

Overview:
Sequencer for the host-memory page fetcher in the sys_clk domain. Walks a run of consecutive 4 KiB host pages: programs the fetch address, pulses the fetch start, waits for the end or timeout events, and retries failures a bounded number of times. Hands each fetched page to a downstream consumer (hash/compare engine reading the page buffer) over a valid/ready handshake before issuing the next fetch, so the page buffer is never overwritten while in use.

Parameters:
PFN_W, 52, page-frame-number width; hm_addr = {pfn, 12'b0}
CNT_W, 16, width of page count/index and gap counter
RTY_W, 4, width of per-page retry limit
WDOG_W, 20, watchdog width; a fetch outstanding 2^WDOG_W-1 cycles counts as a timeout

Ports:
sys_clk  in  1  clock
sys_rst  in  1  synchronous reset, active high
cfg_base  in  PFN_W  first page frame number
cfg_count  in  CNT_W  number of pages to scan
cfg_retries  in  RTY_W  maximum retries per page
cfg_gap  in  CNT_W  idle cycles between fetches
ctl_start  in  1  start-scan pulse
ctl_abort  in  1  abort pulse
hm_start  out  1  one-cycle fetch start to the fetcher
hm_addr  out  64  fetch address, stable from ISSUE until the next ISSUE
hm_end  in  1  fetch-complete event pulse
hm_tx_timeout  in  1  tx timeout event pulse
hm_rx_timeout  in  1  rx timeout event pulse
page_valid  out  1  page buffer holds page page_idx
page_ready  in  1  consumer has released the buffer
page_idx  out  CNT_W  index of the current page within the scan
busy  out  1  scan in progress
scan_done  out  1  one-cycle pulse at scan end (normal or abort)
scan_error  out  1  qualifies scan_done: at least one page failed, or the scan was aborted
stat_retries  out  16  retries in the current/last scan, saturating
stat_fails  out  16  pages skipped in the current/last scan, saturating

Behaviour:
- Reset: state IDLE; every output 0, including hm_addr and both stats.
- States: IDLE, ISSUE, WAIT, DELIVER, GAP.
- IDLE + ctl_start:
  - Latch all cfg_* inputs; later cfg changes are ignored until the next start.
  - Clear idx, tries and stats.
  - If cfg_count==0: pulse scan_done next cycle, scan_error=0, stay IDLE.
  - Otherwise go to ISSUE with busy=1 from the next cycle.
- ctl_start while busy is ignored.
- ISSUE (1 cycle):
  - hm_addr = {(base+idx) mod 2^PFN_W, 12'b0}, registered.
  - hm_start=1 for exactly this cycle; clear the watchdog; go to WAIT.
- WAIT: the watchdog increments each cycle.
  - hm_end -> DELIVER. hm_end has priority over a same-cycle timeout.
  - Failure = hm_tx_timeout, hm_rx_timeout, or watchdog reaching all-ones:
    - If tries<cfg_retries: tries++, stat_retries++, go to GAP, then reissue the same idx.
    - Else stat_fails++, skip the page with no DELIVER, then ADVANCE.
- DELIVER:
  - page_valid=1 and page_idx=idx, held until page_ready.
  - On the cycle page_valid&page_ready: page_valid drops next cycle, then ADVANCE.
  - No fetch is issued while page_valid=1.
- ADVANCE (a transition, not a state): tries=0.
  - If idx==count-1: go to IDLE, busy=0, scan_done pulse, scan_error = (stat_fails!=0).
  - Else idx++ and go to GAP.
- GAP: lasts max(1, cfg_gap) cycles, then ISSUE.
- ctl_abort (priority over everything except sys_rst):
  - Any non-IDLE state -> IDLE next cycle; page_valid and busy drop.
  - scan_done=1 and scan_error=1 for one cycle; hm_start is not asserted.
  - Abort in IDLE has no effect.
- hm_end or timeout events arriving in IDLE, ISSUE, GAP or DELIVER are ignored. Late events from an aborted fetch are dropped.
- Stats saturate at 16'hFFFF and hold their values after the scan ends.
- Throughput with cfg_gap=0 and page_ready tied high is 1 (GAP) + 1 (ISSUE) + fetch latency + 1 (DELIVER) cycles per page.

Test Plan:
- base=0x12345, count=3, gap=0, retries=0, ready=1, hm_end 10 cycles after each hm_start -> three hm_start pulses with hm_addr 0x12345000, 0x12346000, 0x12347000; page_idx 0,1,2; scan_done=1, scan_error=0; busy drops with scan_done.
- count=2, retries=2; page 0: rx_timeout, tx_timeout, then hm_end -> three fetches at the same address, stat_retries=2, page 0 delivered; then page 1 -> stat_fails=0, scan_error=0.
- count=2, retries=1; page 0 always times out -> 2 fetches for page 0, no page_valid for idx 0, stat_fails=1, page 1 delivered; scan_done with scan_error=1.
- ready held low 50 cycles in DELIVER -> page_valid stays high, no hm_start in that window; next hm_start follows cfg_gap cycles after the handshake. Also: hm_end and rx_timeout in the same WAIT cycle -> treated as success.
- ctl_abort during WAIT, then a late hm_end -> IDLE, scan_done=1, scan_error=1, late hm_end ignored; a new ctl_start restarts at idx 0 with stats cleared.
- cfg_count=0 start -> scan_done pulse one cycle later, no hm_start. Also: base=all-ones PFN, count=2 -> second address wraps to 0x0000000000000000. Also: sys_rst mid-WAIT -> all outputs 0 next cycle.
